ahb_interconnect: RTL

//  Parametrised single-master AHB fabric between the CPU master and NUM_SLAVES slaves (SRAM, uart, ...).

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_interconnect_if.sv | 33 +++
 rtl/ahb_default_slave.sv | 87 ++++++++
 rtl/ahb_interconnect.sv | 105 ++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers for the single-master interconnect.
// Holds the transfer/response codes, the default-slave state type and the DEFAULT owner index.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // The data-phase owner uses one index past the last mapped slave for the default slave.
    function automatic int dsel_default(input int num_slaves);
        return num_slaves;
    endfunction

endpackage

// File: rtl/ahb_interconnect_if.sv
// AHB bus bundle between the CPU master, the interconnect and the mapped slaves.
// The slave modport is the interconnect's view; the master modport is the CPU's view.
interface ahb_interconnect_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);

    logic [ADDR_W-1:0]            HADDR;
    logic [1:0]                   HTRANS;
    logic                         HWRITE;
    logic                         HREADY;
    logic [DATA_W-1:0]            HRDATA;
    logic [1:0]                   HRESP;

    logic [NUM_SLAVES-1:0]        HSELx;
    logic [NUM_SLAVES*DATA_W-1:0] S_HRDATA;
    logic [NUM_SLAVES-1:0]        S_HREADYOUT;
    logic [NUM_SLAVES*2-1:0]      S_HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE,
        output HREADY, HRDATA, HRESP,
        output HSELx,
        input  S_HRDATA, S_HREADYOUT, S_HRESP
    );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped space: two-cycle ERROR response plus error log
// (saturating count, faulting address and write flag).
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                clock,
    input  logic                Rst,
    input  logic                hready_i,
    input  logic                hit_any_i,
    input  logic                active_i,
    input  logic [ADDR_W-1:0]   haddr_i,
    input  logic                hwrite_i,
    output logic                ds_hready_o,
    output logic [1:0]          ds_hresp_o,
    output logic [ERRCNT_W-1:0] err_count_o,
    output logic [ADDR_W-1:0]   err_addr_o,
    output logic                err_write_o
);

    ds_state_t             state_q;
    logic                  ds_hready_q;
    logic [1:0]            ds_hresp_q;
    logic [ERRCNT_W-1:0]   err_count_q;
    logic [ERRCNT_W-1:0]   err_count_d;
    logic [ADDR_W-1:0]     err_addr_q;
    logic                  err_write_q;
    logic                  start;

    // A new error starts only when an active unmapped transfer is actually accepted.
    assign start = hready_i && !hit_any_i && active_i;

    always_comb begin
        err_count_d = err_count_q;
        if (err_count_q != {ERRCNT_W{1'b1}}) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            state_q     <= DS_IDLE;
            ds_hready_q <= 1'b1;
            ds_hresp_q  <= HRESP_OKAY;
            err_count_q <= '0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
        end else begin
            case (state_q)
                DS_IDLE, DS_ERR2: begin
                    if (start) begin
                        state_q     <= DS_ERR1;
                        ds_hready_q <= 1'b0;
                        ds_hresp_q  <= HRESP_ERROR;
                        err_count_q <= err_count_d;
                        err_addr_q  <= haddr_i;
                        err_write_q <= hwrite_i;
                    end else begin
                        state_q     <= DS_IDLE;
                        ds_hready_q <= 1'b1;
                        ds_hresp_q  <= HRESP_OKAY;
                    end
                end
                // HTRANS may be cancelled to IDLE here; the second ERROR cycle still follows.
                DS_ERR1: begin
                    state_q     <= DS_ERR2;
                    ds_hready_q <= 1'b1;
                    ds_hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= DS_IDLE;
                    ds_hready_q <= 1'b1;
                    ds_hresp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign ds_hready_o = ds_hready_q;
    assign ds_hresp_o  = ds_hresp_q;
    assign err_count_o = err_count_q;
    assign err_addr_o  = err_addr_q;
    assign err_write_o = err_write_q;

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB fabric: address decode to one-hot HSELx, registered data-phase owner,
// and return mux of slave responses, with a built-in default slave for unmapped space.
module ahb_interconnect
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    parameter int ERRCNT_W   = 16
) (
    input  logic                clock,
    input  logic                Rst,
    ahb_interconnect_if.slave   bus,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                err_write
);

    localparam int DSEL_W = $clog2(NUM_SLAVES + 1);
    localparam logic [DSEL_W-1:0] DSEL_DEF = DSEL_W'(dsel_default(NUM_SLAVES));

    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] hsel;
    logic                  hit_any;
    logic                  active;
    logic [DSEL_W-1:0]     dsel_d;
    logic [DSEL_W-1:0]     dsel_q;
    logic                  hready;
    logic [DATA_W-1:0]     hrdata;
    logic [1:0]            hresp;
    logic                  ds_hready;
    logic [1:0]            ds_hresp;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = (bus.HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W];
        end
    end

    // Walk from the top down so the lowest matching index wins on overlapping windows.
    always_comb begin
        dsel_d = DSEL_DEF;
        hsel   = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dsel_d  = DSEL_W'(i);
                hsel    = '0;
                hsel[i] = 1'b1;
            end
        end
    end

    assign hit_any   = |hit;
    assign active    = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
    assign bus.HSELx = hsel;

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            dsel_q <= DSEL_DEF;
        end else if (hready) begin
            dsel_q <= dsel_d;
        end
    end

    always_comb begin
        hrdata = '0;
        hready = ds_hready;
        hresp  = ds_hresp;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_q == DSEL_W'(i)) begin
                hrdata = bus.S_HRDATA[i*DATA_W +: DATA_W];
                hready = bus.S_HREADYOUT[i];
                hresp  = bus.S_HRESP[i*2 +: 2];
            end
        end
    end

    assign bus.HRDATA = hrdata;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;

    ahb_default_slave #(
        .ADDR_W   (ADDR_W),
        .ERRCNT_W (ERRCNT_W)
    ) u_default_slave (
        .clock       (clock),
        .Rst         (Rst),
        .hready_i    (hready),
        .hit_any_i   (hit_any),
        .active_i    (active),
        .haddr_i     (bus.HADDR),
        .hwrite_i    (bus.HWRITE),
        .ds_hready_o (ds_hready),
        .ds_hresp_o  (ds_hresp),
        .err_count_o (err_count),
        .err_addr_o  (err_addr),
        .err_write_o (err_write)
    );

endmodule
